// File: rtl/fast9_corner_detect.sv
// -----------------------------------------------------------------------------
// fast9_corner_detect
//
// Three-stage pipelined FAST-9 segment test on a stream of 7x7 windows
// (radius-3 Bresenham ring plus centre), one window per centre pixel in raster
// order. Detections whose window would overlap the image border are forced to
// zero using an internal frame-position tracker.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-low reset
//   win_valid     window beat valid (one beat per centre pixel, raster order)
//   win_sof       start of frame, qualified by win_valid; beat is pixel (0,0)
//   centre        window centre pixel
//   circle        16 ring pixels, slot k at [k*DATA_WIDTH +: DATA_WIDTH],
//                 clockwise starting above the centre
//   threshold     FAST threshold t, sampled with each beat
//   corner_valid  result beat valid, 3 cycles after win_valid
//   corner_flag   1 = corner at this centre
//   corner_score  corner strength, 0 when corner_flag = 0
//   corner_x/y    centre coordinate of the result beat
// Result fields hold their last values while corner_valid = 0.
// -----------------------------------------------------------------------------
module fast9_corner_detect #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int SCORE_WIDTH  = DATA_WIDTH + 4,
  localparam int XW = $clog2(IMAGE_WIDTH),
  localparam int YW = $clog2(IMAGE_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     win_valid,
  input  logic                     win_sof,
  input  logic [DATA_WIDTH-1:0]    centre,
  input  logic [16*DATA_WIDTH-1:0] circle,
  input  logic [DATA_WIDTH-1:0]    threshold,
  output logic                     corner_valid,
  output logic                     corner_flag,
  output logic [SCORE_WIDTH-1:0]   corner_score,
  output logic [XW-1:0]            corner_x,
  output logic [YW-1:0]            corner_y
);

  // Classification arithmetic: two extra bits cover c+t up to 2*max and
  // differences down to -2*max without wrap.
  localparam int AW = DATA_WIDTH + 2;

  localparam logic [XW-1:0] X_LAST  = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] X_MIN   = XW'(3);
  localparam logic [XW-1:0] X_MAX   = XW'(IMAGE_WIDTH - 4);
  localparam logic [YW-1:0] Y_MIN   = YW'(3);
  localparam logic [YW-1:0] Y_MAX   = YW'(IMAGE_HEIGHT - 4);

  // True when any 9 circularly contiguous bits of the mask are set.
  // Doubling the mask turns the wrap from slot 15 to slot 0 into a plain slice.
  function automatic logic run9(input logic [15:0] m);
    logic [31:0] mm;
    logic        hit;
    mm  = {m, m};
    hit = 1'b0;
    for (int s = 0; s < 16; s++) begin
      hit = hit | (&mm[s +: 9]);
    end
    return hit;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame position tracking
  // ---------------------------------------------------------------------------
  logic [XW-1:0] x_q, x_d, beat_x_s;
  logic [YW-1:0] y_q, y_d, beat_y_s;

  // Beat coordinate (sof forces origin) and the position of the next beat.
  always_comb begin
    beat_x_s = win_sof ? {XW{1'b0}} : x_q;
    beat_y_s = win_sof ? {YW{1'b0}} : y_q;
    x_d      = x_q;
    y_d      = y_q;
    if (win_valid) begin
      if (beat_x_s == X_LAST) begin
        x_d = {XW{1'b0}};
        y_d = (beat_y_s == Y_LAST) ? {YW{1'b0}} : beat_y_s + YW'(1);
      end else begin
        x_d = beat_x_s + XW'(1);
        y_d = beat_y_s;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Position counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= {XW{1'b0}};
      y_q <= {YW{1'b0}};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: per-slot bright/dark classification and score contributions
  // ---------------------------------------------------------------------------
  logic signed [AW-1:0] c_s, t_s, hi_s, lo_s;
  logic signed [AW-1:0] p_s  [16];
  logic signed [AW-1:0] db_s [16];
  logic signed [AW-1:0] dd_s [16];
  logic [15:0]          bright_s, dark_s;

  // Compare every ring pixel against c+t and c-t in widened signed arithmetic.
  always_comb begin
    c_s  = signed'({2'b00, centre});
    t_s  = signed'({2'b00, threshold});
    hi_s = c_s + t_s;
    lo_s = c_s - t_s;
    for (int k = 0; k < 16; k++) begin
      p_s[k]      = signed'({2'b00, circle[k*DATA_WIDTH +: DATA_WIDTH]});
      db_s[k]     = p_s[k] - hi_s;
      dd_s[k]     = lo_s - p_s[k];
      bright_s[k] = (p_s[k] > hi_s);
      dark_s[k]   = (p_s[k] < lo_s);
    end
  end

  logic                 s1_valid_q;
  logic [15:0]          s1_bright_q, s1_dark_q;
  logic signed [AW-1:0] s1_db_q [16];
  logic signed [AW-1:0] s1_dd_q [16];
  logic [XW-1:0]        s1_x_q;
  logic [YW-1:0]        s1_y_q;

  // Stage 1 registers; data only loads on a valid beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_bright_q <= 16'h0000;
      s1_dark_q   <= 16'h0000;
      s1_x_q      <= {XW{1'b0}};
      s1_y_q      <= {YW{1'b0}};
      for (int k = 0; k < 16; k++) begin
        s1_db_q[k] <= {AW{1'b0}};
        s1_dd_q[k] <= {AW{1'b0}};
      end
    end else begin
      s1_valid_q <= win_valid;
      if (win_valid) begin
        s1_bright_q <= bright_s;
        s1_dark_q   <= dark_s;
        s1_x_q      <= beat_x_s;
        s1_y_q      <= beat_y_s;
        for (int k = 0; k < 16; k++) begin
          s1_db_q[k] <= db_s[k];
          s1_dd_q[k] <= dd_s[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: contiguous-run test and score sums
  // ---------------------------------------------------------------------------
  logic                   seg_b_s, seg_d_s;
  logic [SCORE_WIDTH-1:0] sum_b_s, sum_d_s;

  // Contributions are positive for classified slots, so zero-extension is exact.
  always_comb begin
    seg_b_s = run9(s1_bright_q);
    seg_d_s = run9(s1_dark_q);
    sum_b_s = {SCORE_WIDTH{1'b0}};
    sum_d_s = {SCORE_WIDTH{1'b0}};
    for (int k = 0; k < 16; k++) begin
      sum_b_s = sum_b_s + (s1_bright_q[k] ? {{(SCORE_WIDTH-AW){1'b0}}, s1_db_q[k]}
                                          : {SCORE_WIDTH{1'b0}});
      sum_d_s = sum_d_s + (s1_dark_q[k]   ? {{(SCORE_WIDTH-AW){1'b0}}, s1_dd_q[k]}
                                          : {SCORE_WIDTH{1'b0}});
    end
  end

  logic                   s2_valid_q, s2_seg_b_q, s2_seg_d_q;
  logic [SCORE_WIDTH-1:0] s2_sum_b_q, s2_sum_d_q;
  logic [XW-1:0]          s2_x_q;
  logic [YW-1:0]          s2_y_q;

  // Stage 2 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_seg_b_q <= 1'b0;
      s2_seg_d_q <= 1'b0;
      s2_sum_b_q <= {SCORE_WIDTH{1'b0}};
      s2_sum_d_q <= {SCORE_WIDTH{1'b0}};
      s2_x_q     <= {XW{1'b0}};
      s2_y_q     <= {YW{1'b0}};
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_seg_b_q <= seg_b_s;
        s2_seg_d_q <= seg_d_s;
        s2_sum_b_q <= sum_b_s;
        s2_sum_d_q <= sum_d_s;
        s2_x_q     <= s1_x_q;
        s2_y_q     <= s1_y_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: border suppression, score selection, output registers
  // ---------------------------------------------------------------------------
  logic                   inside_s, flag_s;
  logic [SCORE_WIDTH-1:0] sb_s, sd_s, score_s;

  // A window touching the border has no valid ring, so its detection is dropped.
  always_comb begin
    inside_s = (s2_x_q >= X_MIN) && (s2_x_q <= X_MAX) &&
               (s2_y_q >= Y_MIN) && (s2_y_q <= Y_MAX);
    flag_s   = (s2_seg_b_q | s2_seg_d_q) & inside_s;
    sb_s     = s2_seg_b_q ? s2_sum_b_q : {SCORE_WIDTH{1'b0}};
    sd_s     = s2_seg_d_q ? s2_sum_d_q : {SCORE_WIDTH{1'b0}};
    if (!flag_s) begin
      score_s = {SCORE_WIDTH{1'b0}};
    end else if (sb_s >= sd_s) begin
      score_s = sb_s;
    end else begin
      score_s = sd_s;
    end
  end

  // Output registers; result fields hold while no beat is present.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corner_valid <= 1'b0;
      corner_flag  <= 1'b0;
      corner_score <= {SCORE_WIDTH{1'b0}};
      corner_x     <= {XW{1'b0}};
      corner_y     <= {YW{1'b0}};
    end else begin
      corner_valid <= s2_valid_q;
      if (s2_valid_q) begin
        corner_flag  <= flag_s;
        corner_score <= score_s;
        corner_x     <= s2_x_q;
        corner_y     <= s2_y_q;
      end
    end
  end

endmodule

// File: tb/tb_fast9_corner_detect.sv
// Self-checking bench for fast9_corner_detect on a reduced 40x24 frame.
module tb_fast9_corner_detect;

  localparam int DW = 8;
  localparam int W  = 40;
  localparam int H  = 24;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          win_valid;
  logic          win_sof;
  logic [7:0]    centre;
  logic [127:0]  circle;
  logic [7:0]    threshold;
  logic          corner_valid;
  logic          corner_flag;
  logic [11:0]   corner_score;
  logic [5:0]    corner_x;
  logic [4:0]    corner_y;

  fast9_corner_detect #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .SCORE_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .win_sof(win_sof),
    .centre(centre), .circle(circle), .threshold(threshold),
    .corner_valid(corner_valid), .corner_flag(corner_flag),
    .corner_score(corner_score), .corner_x(corner_x), .corner_y(corner_y)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit f; int s; int x; int y; } exp_t;

  exp_t ring [8];
  exp_t held;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   nvalid = 0;
  int   nflag  = 0;
  int   mx = 0;
  int   my = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: FAST-9 from the rules, plain integers.
  function automatic void model(input int p[16], input int c, input int t,
                                input int x, input int y,
                                output bit f, output int s);
    bit br[16];
    bit dk[16];
    int sb, sd;
    bit segb, segd, ins, run_b, run_d;
    sb = 0; sd = 0; segb = 0; segd = 0;
    for (int k = 0; k < 16; k++) begin
      br[k] = p[k] > c + t;
      dk[k] = p[k] < c - t;
      if (br[k]) sb += p[k] - c - t;
      if (dk[k]) sd += c - t - p[k];
    end
    for (int st = 0; st < 16; st++) begin
      run_b = 1; run_d = 1;
      for (int j = 0; j < 9; j++) begin
        if (!br[(st + j) % 16]) run_b = 0;
        if (!dk[(st + j) % 16]) run_d = 0;
      end
      if (run_b) segb = 1;
      if (run_d) segd = 1;
    end
    ins = (x >= 3) && (x <= W - 4) && (y >= 3) && (y <= H - 4);
    f = (segb || segd) && ins;
    if (!segb) sb = 0;
    if (!segd) sd = 0;
    s = f ? ((sb > sd) ? sb : sd) : 0;
  endfunction

  task automatic check_lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_ring();
    for (int i = 0; i < 8; i++) ring[i] = '{v: 0, f: 0, s: 0, x: 0, y: 0};
  endtask

  // Drive one cycle of input and record what the output must be 3 edges later.
  task automatic beat(input bit v, input bit sof, input int c, input int p[16], input int t);
    exp_t e;
    @(negedge clk);
    win_valid = v;
    win_sof   = sof;
    centre    = 8'(c);
    threshold = 8'(t);
    for (int k = 0; k < 16; k++) circle[k*8 +: 8] = 8'(p[k]);
    e = '{v: 0, f: 0, s: 0, x: 0, y: 0};
    if (v) begin
      if (sof) begin mx = 0; my = 0; end
      e.v = 1; e.x = mx; e.y = my;
      model(p, c, t, mx, my, e.f, e.s);
      if (mx == W - 1) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    ring[cyc % 8] = e;
  endtask

  task automatic idle();
    int p[16];
    for (int k = 0; k < 16; k++) p[k] = $urandom_range(0, 255);
    beat(0, 0, $urandom_range(0, 255), p, $urandom_range(0, 255));
  endtask

  // Directed ring patterns, all with centre 100 and t 20.
  task automatic set_pat(input int kind, output int p[16]);
    for (int k = 0; k < 16; k++) p[k] = 100;
    case (kind)
      0: for (int k = 0; k < 9; k++) p[k] = 130;
      1: for (int k = 0; k < 9; k++) p[(12 + k) % 16] = 60;
      2: for (int k = 0; k < 8; k++) p[(12 + k) % 16] = 60;
      3: for (int k = 0; k < 9; k++) p[k] = 120;
      default: for (int k = 0; k < 9; k++) p[k] = 121;
    endcase
  endtask

  task automatic rand_beat(input bit sof);
    int p[16];
    int c, t, kind, st, len, v;
    c = $urandom_range(0, 255);
    t = $urandom_range(0, 50);
    kind = $urandom_range(0, 3);
    for (int k = 0; k < 16; k++) p[k] = $urandom_range(0, 255);
    if (kind == 1 || kind == 2) begin
      st  = $urandom_range(0, 15);
      len = $urandom_range(7, 12);
      for (int j = 0; j < len; j++) begin
        if (kind == 1) begin
          v = c + t + $urandom_range(0, 30);
          if (v > 255) v = 255;
        end else begin
          v = c - t - $urandom_range(0, 30);
          if (v < 0) v = 0;
        end
        p[(st + j) % 16] = v;
      end
    end else if (kind == 3) begin
      for (int k = 0; k < 16; k++) p[k] = c;
      t = $urandom_range(0, 2);
    end
    beat(1, sof, c, p, t);
  endtask

  // Compare process: every cycle against the recorded expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      held = '{v: 0, f: 0, s: 0, x: 0, y: 0};
      checks++;
      if ({corner_valid, corner_flag, corner_score, corner_x, corner_y} !== 25'd0) begin
        errors++;
        $display("FAIL reset-outputs cyc=%0d got v=%0b f=%0b s=%0d x=%0d y=%0d expected all 0",
                 cyc, corner_valid, corner_flag, corner_score, corner_x, corner_y);
      end
    end else if (cyc >= 3) begin
      e = ring[(cyc - 3) % 8];
      if (e.v) held = e;
      if (corner_valid === 1'b1) nvalid++;
      if (corner_valid === 1'b1 && corner_flag === 1'b1) nflag++;
      checks++;
      if ({corner_valid, corner_flag, corner_score, corner_x, corner_y} !==
          {e.v, held.f, 12'(held.s), 6'(held.x), 5'(held.y)}) begin
        errors++;
        $display("FAIL cycle-check cyc=%0d got v=%0b f=%0b s=%0d x=%0d y=%0d expected v=%0b f=%0b s=%0d x=%0d y=%0d",
                 cyc, corner_valid, corner_flag, corner_score, corner_x, corner_y,
                 e.v, held.f, held.s, held.x, held.y);
      end
    end
  end

  int sp_idx  [11] = '{90, 123, 402, 410, 420, 425, 430, 433, 437, 836, 850};
  int sp_kind [11] = '{0,  0,   0,   0,   1,   2,   3,   4,   0,   0,   0};
  int sp_f    [11] = '{0,  1,   0,   1,   1,   0,   0,   1,   0,   1,   0};
  int sp_s    [11] = '{0,  90,  0,   90,  180, 0,   0,   9,   0,   90,  0};

  initial begin
    int p[16];
    int m;
    clear_ring();
    held = '{v: 0, f: 0, s: 0, x: 0, y: 0};
    rst = 1'b0; win_valid = 1'b0; win_sof = 1'b0;
    centre = 8'd0; circle = 128'd0; threshold = 8'd0;
    repeat (4) @(negedge clk);
    check_lit("reset valid", int'(corner_valid), 0);
    check_lit("reset score", int'(corner_score), 0);
    #2 rst = 1'b1;

    // Frame A: flat image, no detections anywhere.
    nvalid = 0; nflag = 0;
    for (int k = 0; k < 16; k++) p[k] = 100;
    for (int i = 0; i < W * H; i++) beat(1, i == 0, 100, p, 20);
    repeat (4) idle();
    check_lit("flat beats", nvalid, W * H);
    check_lit("flat flags", nflag, 0);
    check_lit("flat last x", int'(corner_x), W - 1);
    check_lit("flat last y", int'(corner_y), H - 1);
    check_lit("flat score", int'(corner_score), 0);

    // Frame B: directed patterns at fixed positions, random windows and gaps elsewhere.
    for (int idx = 0; idx < W * H; idx++) begin
      m = -1;
      for (int j = 0; j < 11; j++) if (sp_idx[j] == idx) m = j;
      if (m >= 0) begin
        set_pat(sp_kind[m], p);
        beat(1, 0, 100, p, 20);
        repeat (3) idle();
        check_lit($sformatf("pat%0d flag", idx), int'(corner_flag), sp_f[m]);
        check_lit($sformatf("pat%0d score", idx), int'(corner_score), sp_s[m]);
        check_lit($sformatf("pat%0d x", idx), int'(corner_x), idx % W);
        check_lit($sformatf("pat%0d y", idx), int'(corner_y), idx / W);
      end else begin
        if ($urandom_range(0, 4) == 0) idle();
        rand_beat(idx == 0);
      end
    end
    repeat (3) idle();

    // Frame C: asynchronous reset mid-frame with beats still arriving.
    rand_beat(1);
    repeat (49) rand_beat(0);
    check_lit("pre-reset valid", int'(corner_valid), 1);
    #2 rst = 1'b0;
    clear_ring();
    mx = 0; my = 0;
    #1;
    check_lit("async valid", int'(corner_valid), 0);
    check_lit("async flag", int'(corner_flag), 0);
    check_lit("async score", int'(corner_score), 0);
    check_lit("async x", int'(corner_x), 0);
    check_lit("async y", int'(corner_y), 0);
    repeat (2) begin
      @(negedge clk);
      win_valid = 1'b1;
      for (int k = 0; k < 16; k++) circle[k*8 +: 8] = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    win_valid = 1'b0;
    #2 rst = 1'b1;
    set_pat(0, p);
    beat(1, 1, 100, p, 20);
    repeat (3) idle();
    check_lit("post-reset sof x", int'(corner_x), 0);
    check_lit("post-reset sof y", int'(corner_y), 0);
    check_lit("post-reset sof flag", int'(corner_flag), 0);

    // Start of frame in the middle of a line restarts at the origin.
    for (int i = 0; i < 200 && !(mx == 25 && my == 1); i++) rand_beat(0);
    beat(1, 1, 100, p, 20);
    repeat (3) idle();
    check_lit("mid-line sof x", int'(corner_x), 0);
    check_lit("mid-line sof y", int'(corner_y), 0);
    beat(1, 0, 100, p, 20);
    repeat (3) idle();
    check_lit("after sof x", int'(corner_x), 1);
    check_lit("after sof y", int'(corner_y), 0);
    repeat (20) rand_beat(0);
    repeat (4) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
